// File: rtl/obi_ahb_pkg.sv
// obi_ahb_pkg: AHB-Lite encodings and the OBI byte-enable decode shared by the bridge.
package obi_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;

    typedef struct packed {
        logic       ok;
        logic [2:0] hsize;
        logic [2:0] addr_lsb;
    } be_dec_t;

    // Legal patterns are aligned runs of 1, 2, 4 or 8 enables; alignment also keeps every mask inside 8 bits.
    function automatic be_dec_t be_decode(input logic [7:0] be);
        be_dec_t r;
        r = '0;
        for (int s = 0; s < 4; s++) begin
            for (int o = 0; o < 8; o++) begin
                if (o % (1 << s) == 0 && be == 8'(((1 << (1 << s)) - 1) << o)) begin
                    r.ok       = 1'b1;
                    r.hsize    = 3'(s);
                    r.addr_lsb = 3'(o);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/obi_ahb_resp_fifo.sv
// obi_ahb_resp_fifo: in-order response queue; the head entry is visible without a read cycle.
module obi_ahb_resp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= push_data;
        end
    end

    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/obi2ahbm_bridge.sv
// obi2ahbm_bridge: OBI v1.5 data port to AHB-Lite master with registered A/D stages,
// credit-limited response FIFO and two-cycle ERROR cancel-and-replay.
module obi2ahbm_bridge
    import obi_ahb_pkg::*;
#(
    parameter int   ADDR_W     = 32,
    parameter int   DATA_W     = 32,
    parameter int   RESP_DEPTH = 4,
    parameter logic HPROT_DATA = 1'b1
) (
    input  logic                hclk_i,
    input  logic                hreset_i,
    output logic [ADDR_W-1:0]   haddr_o,
    output logic [1:0]          htrans_o,
    output logic [2:0]          hsize_o,
    output logic [2:0]          hburst_o,
    output logic                hmastlock_o,
    output logic [3:0]          hprot_o,
    output logic                hwrite_o,
    output logic [DATA_W-1:0]   hwdata_o,
    input  logic [DATA_W-1:0]   hrdata_i,
    input  logic                hready_i,
    input  logic                hresp_i,
    input  logic                data_req_i,
    output logic                data_gnt_o,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_rvalid_o,
    input  logic                data_rready_i,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_err_o,
    input  logic                pending_dbus_xfer_i,
    input  logic                priv_mode_i
);
    localparam int BE_W = DATA_W / 8;
    localparam int CW   = $clog2(RESP_DEPTH) + 1;

    logic              a_valid_q, a_valid_d, a_bad_q, a_bad_d, a_we_q, a_we_d, a_priv_q, a_priv_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
    logic [2:0]        a_size_q, a_size_d;
    logic              d_valid_q, d_valid_d, d_we_q, d_we_d, d_bad_q, d_bad_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
    logic              err_hold_q, err_hold_d;
    logic [CW-1:0]     out_q, out_d;
    logic              err_now, a_adv, d_done, pop, push;
    logic [DATA_W:0]   resp_in, resp_head;
    logic              resp_full, resp_empty;
    logic [CW-1:0]     resp_cnt;
    be_dec_t           dec;

    always_comb begin
        dec        = be_decode(8'(data_be_i));
        err_now    = hresp_i && !hready_i;
        a_adv      = a_valid_q && hready_i && !err_hold_q;
        d_done     = d_valid_q && hready_i;
        pop        = data_rvalid_o && data_rready_i;
        push       = d_done && !resp_full;
        data_gnt_o = data_req_i && !pending_dbus_xfer_i && !hreset_i &&
                     (out_q - CW'(pop)) < CW'(RESP_DEPTH) && (!a_valid_q || a_adv);
        a_valid_d  = data_gnt_o ? 1'b1 : a_adv ? 1'b0 : a_valid_q;
        a_bad_d    = data_gnt_o ? !dec.ok : a_bad_q;
        a_wdata_d  = data_gnt_o ? data_wdata_i : a_wdata_q;
        // Rejected enables never reach the bus, so the visible A fields keep their last legal values.
        a_addr_d   = (data_gnt_o && dec.ok) ?
                     (data_addr_i & ~ADDR_W'(BE_W - 1)) | ADDR_W'(dec.addr_lsb) : a_addr_q;
        a_we_d     = (data_gnt_o && dec.ok) ? data_we_i : a_we_q;
        a_size_d   = (data_gnt_o && dec.ok) ? dec.hsize : a_size_q;
        a_priv_d   = (data_gnt_o && dec.ok) ? priv_mode_i : a_priv_q;
        d_valid_d  = a_adv ? 1'b1 : d_done ? 1'b0 : d_valid_q;
        d_we_d     = a_adv ? a_we_q : d_we_q;
        d_bad_d    = a_adv ? a_bad_q : d_bad_q;
        d_wdata_d  = a_adv ? a_wdata_q : d_wdata_q;
        err_hold_d = err_now ? 1'b1 : hready_i ? 1'b0 : err_hold_q;
        out_d      = out_q + CW'(data_gnt_o) - CW'(pop);
        resp_in    = {hresp_i || d_bad_q, (d_we_q || d_bad_q) ? '0 : hrdata_i};
    end

    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            a_valid_q  <= 1'b0;
            a_bad_q    <= 1'b0;
            a_addr_q   <= '0;
            a_we_q     <= 1'b0;
            a_size_q   <= HSIZE_BYTE;
            a_priv_q   <= 1'b1;
            a_wdata_q  <= '0;
            d_valid_q  <= 1'b0;
            d_we_q     <= 1'b0;
            d_bad_q    <= 1'b0;
            d_wdata_q  <= '0;
            err_hold_q <= 1'b0;
            out_q      <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_bad_q    <= a_bad_d;
            a_addr_q   <= a_addr_d;
            a_we_q     <= a_we_d;
            a_size_q   <= a_size_d;
            a_priv_q   <= a_priv_d;
            a_wdata_q  <= a_wdata_d;
            d_valid_q  <= d_valid_d;
            d_we_q     <= d_we_d;
            d_bad_q    <= d_bad_d;
            d_wdata_q  <= d_wdata_d;
            err_hold_q <= err_hold_d;
            out_q      <= out_d;
        end
    end

    obi_ahb_resp_fifo #(.WIDTH(DATA_W + 1), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk      (hclk_i),
        .rst      (hreset_i),
        .push     (push),
        .push_data(resp_in),
        .pop      (pop),
        .head     (resp_head),
        .full     (resp_full),
        .empty    (resp_empty),
        .count    (resp_cnt)
    );

    assign htrans_o      = (a_valid_q && !a_bad_q && !err_hold_q && !err_now) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr_o       = a_addr_q;
    assign hsize_o       = a_size_q;
    assign hburst_o      = HBURST_SINGLE;
    assign hmastlock_o   = 1'b0;
    assign hprot_o       = {2'b00, a_priv_q, HPROT_DATA};
    assign hwrite_o      = a_we_q;
    assign hwdata_o      = d_valid_q ? d_wdata_q : '0;
    assign data_rvalid_o = resp_cnt != '0;
    assign {data_err_o, data_rdata_o} = resp_empty ? '0 : resp_head;

endmodule

// File: tb/tb_obi2ahbm_bridge.sv
// tb_obi2ahbm_bridge: directed cycle-by-cycle vectors with hand-computed AHB and OBI expectations.
module tb_obi2ahbm_bridge;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] haddr, hwdata, hrdata = '0, addr = '0, wdata = '0, rdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot, be = 4'hF;
    logic        hmastlock, hwrite, hready = 1'b1, hresp = 1'b0;
    logic        req = 1'b1, gnt, we = 1'b0, rvalid, rready = 1'b1, err, pending = 1'b0, priv = 1'b1;
    int          n_chk = 0, n_pass = 0, n_cnt;

    obi2ahbm_bridge #(.ADDR_W(32), .DATA_W(32), .RESP_DEPTH(4), .HPROT_DATA(1'b1)) dut (
        .hclk_i(clk), .hreset_i(rst), .haddr_o(haddr), .htrans_o(htrans), .hsize_o(hsize),
        .hburst_o(hburst), .hmastlock_o(hmastlock), .hprot_o(hprot), .hwrite_o(hwrite),
        .hwdata_o(hwdata), .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp),
        .data_req_i(req), .data_gnt_o(gnt), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
        .data_wdata_i(wdata), .data_rvalid_o(rvalid), .data_rready_i(rready), .data_rdata_o(rdata),
        .data_err_o(err), .pending_dbus_xfer_i(pending), .priv_mode_i(priv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            req = 0; we = 0; be = 4'hF; hready = 1; hresp = 0; rready = 1; pending = 0;
        end
    endtask

    initial begin
        #12;
        check("rst_htrans", htrans, 2'b00);
        check("rst_haddr", haddr, 0);
        check("rst_hsize", hsize, 0);
        check("rst_hwrite", hwrite, 0);
        check("rst_hwdata", hwdata, 0);
        check("rst_hprot", hprot, 4'b0011);
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        check("tie_hburst", hburst, 3'b000);
        check("tie_hmastlock", hmastlock, 0);
        tick();
        rst = 0; req = 0;
        idle(2);

        for (int i = 0; i < 7; i++) begin
            tick();
            req = (i < 4); addr = 32'h100 + 32'(4 * i); be = 4'hF;
            hrdata = 32'hA000_0100 + 32'(4 * (i - 2));
            #1;
            if (i < 4) check("b2b_gnt", gnt, 1);
            if (i >= 1 && i <= 4) begin
                check("b2b_htrans", htrans, 2'b10);
                check("b2b_haddr", haddr, 32'h100 + 32'(4 * (i - 1)));
                check("b2b_hsize", hsize, 3'b010);
            end
            if (i == 5) check("b2b_idle", htrans, 2'b00);
            if (i == 2) check("b2b_no_early_rvalid", rvalid, 0);
            if (i >= 3) begin
                check("b2b_rvalid", rvalid, 1);
                check("b2b_rdata", rdata, 32'hA000_0100 + 32'(4 * (i - 3)));
                check("b2b_err", err, 0);
            end
        end
        idle(1);
        #1 check("b2b_drained", rvalid, 0);
        idle(2);

        tick(); req = 1; addr = 32'h200; be = 4'b0100;
        #1 check("sz_gnt0", gnt, 1);
        tick(); be = 4'b1100;
        #1 check("sz_b_htrans", htrans, 2'b10);
        check("sz_b_haddr", haddr, 32'h202);
        check("sz_b_hsize", hsize, 3'b000);
        check("sz_gnt1", gnt, 1);
        tick(); be = 4'b0110; hrdata = 32'h1122_3344;
        #1 check("sz_h_htrans", htrans, 2'b10);
        check("sz_h_haddr", haddr, 32'h202);
        check("sz_h_hsize", hsize, 3'b001);
        check("sz_gnt2", gnt, 1);
        tick(); req = 0; hrdata = 32'h5566_7788;
        #1 check("sz_bad_idle", htrans, 2'b00);
        check("sz_bad_haddr_held", haddr, 32'h202);
        check("sz_r0_data", rdata, 32'h1122_3344);
        tick(); hrdata = 32'hFFFF_FFFF;
        #1 check("sz_bad_idle2", htrans, 2'b00);
        check("sz_r1_data", rdata, 32'h5566_7788);
        check("sz_r1_err", err, 0);
        tick();
        #1 check("sz_r2_rvalid", rvalid, 1);
        check("sz_r2_err", err, 1);
        check("sz_r2_rdata", rdata, 0);
        idle(3);

        tick(); req = 1; addr = 32'h300; be = 4'hF;
        #1 check("er_gnt0", gnt, 1);
        tick(); addr = 32'h304;
        #1 check("er_a0", haddr, 32'h300);
        check("er_gnt1", gnt, 1);
        tick(); req = 0; hresp = 1; hready = 0; hrdata = 0;
        #1 check("er_idle1", htrans, 2'b00);
        tick(); hready = 1;
        #1 check("er_idle2", htrans, 2'b00);
        tick(); hresp = 0;
        #1 check("er_replay_htrans", htrans, 2'b10);
        check("er_replay_haddr", haddr, 32'h304);
        check("er_r0_rvalid", rvalid, 1);
        check("er_r0_err", err, 1);
        tick(); hrdata = 32'hCAFE_0304;
        #1 check("er_gap", rvalid, 0);
        tick();
        #1 check("er_r1_rvalid", rvalid, 1);
        check("er_r1_err", err, 0);
        check("er_r1_rdata", rdata, 32'hCAFE_0304);
        idle(3);

        n_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(); req = 1; rready = 0; addr = 32'h400; hrdata = 32'h400;
            #1 if (gnt) n_cnt++;
        end
        check("bp_grants", n_cnt, 4);
        check("bp_stalled", gnt, 0);
        tick(); rready = 1;
        #1 check("bp_pulse_rvalid", rvalid, 1);
        check("bp_pulse_gnt", gnt, 1);
        n_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); rready = 0;
            #1 if (gnt) n_cnt++;
        end
        check("bp_after_pulse", n_cnt, 0);
        n_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); req = 0; rready = 1;
            #1 if (rvalid) n_cnt++;
        end
        check("bp_drain", n_cnt, 4);
        idle(2);

        tick(); req = 1; we = 1; addr = 32'h500; wdata = 32'hDEAD_BEEF;
        #1 check("wr_gnt", gnt, 1);
        tick(); req = 0; wdata = 0;
        #1 check("wr_hwrite", hwrite, 1);
        check("wr_haddr", haddr, 32'h500);
        for (int i = 0; i < 3; i++) begin
            tick(); hready = (i == 2); hrdata = 32'h1234_5678;
            #1 check("wr_hwdata", hwdata, 32'hDEAD_BEEF);
        end
        tick(); hready = 1;
        #1 check("wr_rvalid", rvalid, 1);
        check("wr_err", err, 0);
        check("wr_rdata", rdata, 0);
        idle(3);

        tick(); req = 1; we = 0; addr = 32'h600;
        #1 check("rs_gnt0", gnt, 1);
        tick(); addr = 32'h604;
        #1 check("rs_a0", htrans, 2'b10);
        tick(); req = 0; hready = 0;
        #1 check("rs_a1_wait", haddr, 32'h604);
        rst = 1;
        #1 check("rs_htrans", htrans, 2'b00);
        check("rs_haddr", haddr, 0);
        check("rs_hwdata", hwdata, 0);
        check("rs_rvalid", rvalid, 0);
        check("rs_hprot", hprot, 4'b0011);
        tick(); tick(); rst = 0; hready = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            #1 check("rs_no_rvalid", rvalid, 0);
            check("rs_no_htrans", htrans, 2'b00);
        end

        tick(); req = 1; addr = 32'h700; be = 4'b0011; priv = 0; pending = 1;
        #1 check("pd_block", gnt, 0);
        pending = 0;
        #1 check("pd_release", gnt, 1);
        tick(); req = 0;
        #1 check("pv_hprot", hprot, 4'b0001);
        check("pv_hsize", hsize, 3'b001);
        check("pv_haddr", haddr, 32'h700);
        tick(); hrdata = 32'h0000_BEEF;
        tick();
        #1 check("pv_rdata", rdata, 32'h0000_BEEF);
        check("pv_rvalid", rvalid, 1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
